// File: rtl/seq_rec_readout_ctrl.sv
// seq_rec_readout_ctrl: programs a sequence recorder, waits for its done bit
// and streams the captured bytes out over a valid/ready byte port.
// Ports: BUS_CLK/RST (sync, active-high); START/COUNT/EXT_EN run request;
// REC_ADD/REC_WR/REC_RD/REC_DOUT/REC_DIN recorder bus; DATA/DATA_VALID/
// DATA_READY readout stream; BUSY/DONE/TIMEOUT status.
// Optional macro SEQ_REC_CTRL_TIMEOUT_EN: bounds polling at TIMEOUT_POLLS
// failed polls and aborts with a recorder soft reset.
module seq_rec_readout_ctrl #(
  parameter int ABUSWIDTH     = 16,
  parameter int BASE_ADDR     = 0,
  parameter int MEM_BYTES     = 8192,
  parameter int TIMEOUT_POLLS = 1048576
) (
  input  logic                 BUS_CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [15:0]          COUNT,
  input  logic                 EXT_EN,
  output logic [ABUSWIDTH-1:0] REC_ADD,
  output logic                 REC_WR,
  output logic                 REC_RD,
  output logic [7:0]           REC_DOUT,
  input  logic [7:0]           REC_DIN,
  output logic [7:0]           DATA,
  output logic                 DATA_VALID,
  input  logic                 DATA_READY,
  output logic                 BUSY,
  output logic                 DONE,
  output logic                 TIMEOUT
);

  localparam logic [ABUSWIDTH-1:0] A_SRST = ABUSWIDTH'(BASE_ADDR);
  localparam logic [ABUSWIDTH-1:0] A_STRT = A_SRST + ABUSWIDTH'(1);
  localparam logic [ABUSWIDTH-1:0] A_CONF = A_SRST + ABUSWIDTH'(2);
  localparam logic [ABUSWIDTH-1:0] A_CNTL = A_SRST + ABUSWIDTH'(3);
  localparam logic [ABUSWIDTH-1:0] A_CNTH = A_SRST + ABUSWIDTH'(4);
  localparam logic [ABUSWIDTH-1:0] A_MEM  = A_SRST + ABUSWIDTH'(16);
  localparam logic [16:0]          MEM_LIM = 17'(MEM_BYTES);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_EN, S_WR_CNTL, S_WR_CNTH,
    S_ARM, S_POLL_RD, S_POLL_CHK, S_RD_REQ,
    S_RD_CAP, S_PUSH, S_FIN, S_ABORT
  } state_t;

  state_t                 state, nxt;
  logic [15:0]            cnt, cnt_d;
  logic [15:0]            idx, idx_d;
  logic                   ext_en, ext_d;
  logic [7:0]             data_d;
  logic                   dv_d;
  logic [ABUSWIDTH-1:0]   add_d;
  logic                   wr_d, rd_d;
  logic [7:0]             dout_d;
  logic [15:0]            count_clamped;
  logic                   poll_fail;
  logic                   poll_last;

  assign count_clamped = ({1'b0, COUNT} > MEM_LIM) ?
                         MEM_LIM[15:0] : COUNT;
  assign poll_fail = (state == S_POLL_CHK) && !REC_DIN[0];
  assign BUSY = (state != S_IDLE);

`ifdef SEQ_REC_CTRL_TIMEOUT_EN
  localparam logic [31:0] POLL_LAST = 32'(TIMEOUT_POLLS - 1);
  logic [31:0] poll_cnt;

  always_ff @(posedge BUS_CLK) begin
    if (RST || state == S_IDLE) poll_cnt <= '0;
    else if (poll_fail)         poll_cnt <= poll_cnt + 32'd1;
  end

  // The failing poll that brings the count to TIMEOUT_POLLS aborts.
  assign poll_last = (poll_cnt == POLL_LAST);

  // ABORT always hands over to FIN, so this lands in the FIN cycle.
  always_ff @(posedge BUS_CLK) begin
    if (RST) TIMEOUT <= 1'b0;
    else     TIMEOUT <= (state == S_ABORT);
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_POLLS != 0) ^ poll_fail;
  assign poll_last = 1'b0;
  assign TIMEOUT   = 1'b0;
`endif

  always_ff @(posedge BUS_CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      ext_en     <= 1'b0;
      DATA       <= '0;
      DATA_VALID <= 1'b0;
      REC_ADD    <= '0;
      REC_WR     <= 1'b0;
      REC_RD     <= 1'b0;
      REC_DOUT   <= '0;
      DONE       <= 1'b0;
    end else begin
      state      <= nxt;
      cnt        <= cnt_d;
      idx        <= idx_d;
      ext_en     <= ext_d;
      DATA       <= data_d;
      DATA_VALID <= dv_d;
      REC_ADD    <= add_d;
      REC_WR     <= wr_d;
      REC_RD     <= rd_d;
      REC_DOUT   <= dout_d;
      DONE       <= (nxt == S_FIN);
    end
  end

  always_comb begin
    nxt    = state;
    cnt_d  = cnt;
    ext_d  = ext_en;
    idx_d  = idx;
    data_d = DATA;
    dv_d   = DATA_VALID;
    unique case (state)
      S_IDLE: begin
        if (START) begin
          cnt_d = count_clamped;
          ext_d = EXT_EN;
          idx_d = '0;
          nxt   = (count_clamped == '0) ?
                  S_FIN : S_WR_EN;
        end
      end
      S_WR_EN:   nxt = S_WR_CNTL;
      S_WR_CNTL: nxt = S_WR_CNTH;
      S_WR_CNTH: nxt = S_ARM;
      S_ARM:     nxt = S_POLL_RD;
      S_POLL_RD: nxt = S_POLL_CHK;
      S_POLL_CHK: begin
        if (REC_DIN[0]) begin
          idx_d = '0;
          nxt   = S_RD_REQ;
        end else if (poll_last) begin
          nxt = S_ABORT;
        end else begin
          nxt = S_POLL_RD;
        end
      end
      S_RD_REQ: nxt = S_RD_CAP;
      S_RD_CAP: begin
        data_d = REC_DIN;
        dv_d   = 1'b1;
        nxt    = S_PUSH;
      end
      S_PUSH: begin
        if (DATA_READY) begin
          dv_d  = 1'b0;
          idx_d = idx + 16'd1;
          nxt   = (idx == cnt - 16'd1) ?
                  S_FIN : S_RD_REQ;
        end
      end
      S_FIN:   nxt = S_IDLE;
      S_ABORT: nxt = S_FIN;
      default: nxt = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they are high exactly
  // in the matching state cycle; REC_ADD/REC_DOUT hold between strobes.
  always_comb begin
    wr_d   = 1'b0;
    rd_d   = 1'b0;
    add_d  = REC_ADD;
    dout_d = REC_DOUT;
    case (nxt)
      S_WR_EN: begin
        wr_d   = 1'b1;
        add_d  = A_CONF;
        dout_d = {7'b0, ext_d};
      end
      S_WR_CNTL: begin
        wr_d   = 1'b1;
        add_d  = A_CNTL;
        dout_d = cnt_d[7:0];
      end
      S_WR_CNTH: begin
        wr_d   = 1'b1;
        add_d  = A_CNTH;
        dout_d = cnt_d[15:8];
      end
      S_ARM: begin
        if (!ext_d) begin
          wr_d   = 1'b1;
          add_d  = A_STRT;
          dout_d = 8'h00;
        end
      end
      S_POLL_RD: begin
        rd_d  = 1'b1;
        add_d = A_STRT;
      end
      S_RD_REQ: begin
        rd_d  = 1'b1;
        add_d = A_MEM + ABUSWIDTH'(idx_d);
      end
      S_ABORT: begin
        wr_d   = 1'b1;
        add_d  = A_SRST;
        dout_d = 8'h00;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_rec_readout_ctrl.sv
// Directed bench for seq_rec_readout_ctrl with a small recorder model.
// Honours SEQ_REC_CTRL_TIMEOUT_EN for the timeout scenario.
module tb_seq_rec_readout_ctrl;

  logic        BUS_CLK;
  logic        RST;
  logic        START;
  logic [15:0] COUNT;
  logic        EXT_EN;
  logic [15:0] REC_ADD;
  logic        REC_WR;
  logic        REC_RD;
  logic [7:0]  REC_DOUT;
  logic [7:0]  REC_DIN;
  logic [7:0]  DATA;
  logic        DATA_VALID;
  logic        DATA_READY;
  logic        BUSY;
  logic        DONE;
  logic        TIMEOUT;

  seq_rec_readout_ctrl #(
    .ABUSWIDTH    (16),
    .BASE_ADDR    (0),
    .MEM_BYTES    (8192),
    .TIMEOUT_POLLS(8)
  ) dut (
    .BUS_CLK   (BUS_CLK),
    .RST       (RST),
    .START     (START),
    .COUNT     (COUNT),
    .EXT_EN    (EXT_EN),
    .REC_ADD   (REC_ADD),
    .REC_WR    (REC_WR),
    .REC_RD    (REC_RD),
    .REC_DOUT  (REC_DOUT),
    .REC_DIN   (REC_DIN),
    .DATA      (DATA),
    .DATA_VALID(DATA_VALID),
    .DATA_READY(DATA_READY),
    .BUSY      (BUSY),
    .DONE      (DONE),
    .TIMEOUT   (TIMEOUT)
  );

  int total = 0;
  int bad   = 0;

  initial begin
    BUS_CLK = 1'b0;
    forever #5 BUS_CLK = ~BUS_CLK;
  end

  // recorder model
  logic [7:0] mem [0:255];
  logic       rec_done;
  int         timer;
  logic       ext_go;
  logic       never_done;

  always @(posedge BUS_CLK) begin
    if (RST) begin
      rec_done <= 1'b0;
      timer    <= 0;
      REC_DIN  <= 8'h00;
    end else begin
      if (REC_WR && REC_ADD == 16'd2) rec_done <= 1'b0;
      if ((REC_WR && REC_ADD == 16'd1) || ext_go) begin
        timer <= 10;
      end else if (timer != 0) begin
        timer <= timer - 1;
        if (timer == 1 && !never_done) rec_done <= 1'b1;
      end
      if (REC_RD) begin
        if (REC_ADD == 16'd1) REC_DIN <= {7'b0, rec_done};
        else REC_DIN <= mem[8'(REC_ADD - 16'd16)];
      end
    end
  end

  // monitors, sampled on the falling edge
  logic [23:0] wr_q [$];
  logic [7:0]  acc_q [$];
  int          acc_cyc [$];
  int cyc = 0;
  int rd_cnt, done_cnt, to_cnt, both_cnt;
  int rw_err = 0, rdv_err = 0, stab_err = 0;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data;

  always @(negedge BUS_CLK) begin
    cyc++;
    if (!RST) begin
      if (DATA_VALID && DATA_READY) begin
        acc_q.push_back(DATA);
        acc_cyc.push_back(cyc);
      end
      if (hold_pend && (!DATA_VALID || DATA !== hold_data))
        stab_err++;
      if (REC_WR) wr_q.push_back({REC_ADD, REC_DOUT});
      if (REC_RD) rd_cnt++;
      if (DONE) done_cnt++;
      if (TIMEOUT) to_cnt++;
      if (DONE && TIMEOUT) both_cnt++;
      if (REC_RD && DATA_VALID) rdv_err++;
      if (REC_RD && REC_WR) rw_err++;
    end
    hold_pend = !RST && DATA_VALID && !DATA_READY;
    hold_data = DATA;
  end

  // ready driver: 0 = always high, 1 = high one cycle in three, 2 = low
  int rdy_mode = 0;
  initial begin
    int k = 0;
    DATA_READY = 1'b1;
    forever begin
      @(posedge BUS_CLK);
      #1;
      k++;
      case (rdy_mode)
        0: DATA_READY = 1'b1;
        1: DATA_READY = (k % 3 == 0);
        default: DATA_READY = 1'b0;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge BUS_CLK);
    #1;
  endtask

  task automatic clr();
    wr_q.delete();
    acc_q.delete();
    acc_cyc.delete();
    rd_cnt = 0;
    done_cnt = 0;
    to_cnt = 0;
    both_cnt = 0;
  endtask

  task automatic start_run(input logic [15:0] c, input logic e);
    step();
    START = 1'b1;
    COUNT = c;
    EXT_EN = e;
    step();
    START = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input string tag);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < maxc) begin
      @(negedge BUS_CLK);
      n++;
    end
    chk(tag, done_cnt != d0, 1);
    step();
    step();
  endtask

  task automatic chk_bytes(input string tag, input int n);
    chk({tag, "_n"}, acc_q.size(), n);
    for (int i = 0; i < n; i++)
      chk({tag, "_byte"}, acc_q[i], 8'hA0 + 8'(i));
  endtask

  task automatic pulse_rst();
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'hA0 + 8'(i);
    RST = 1'b1;
    START = 1'b0;
    COUNT = '0;
    EXT_EN = 1'b0;
    ext_go = 1'b0;
    never_done = 1'b0;
    clr();
    repeat (3) step();
    RST = 1'b0;
    @(negedge BUS_CLK);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_timeout", TIMEOUT, 0);
    chk("rst_dv", DATA_VALID, 0);
    chk("rst_data", DATA, 0);
    chk("rst_add", REC_ADD, 0);
    chk("rst_wr", REC_WR, 0);
    chk("rst_rd", REC_RD, 0);
    chk("rst_dout", REC_DOUT, 0);

    // basic run, ready held high
    clr();
    rdy_mode = 0;
    start_run(16'd4, 1'b0);
    wait_done(300, "run1_done_seen");
    chk("run1_nwr", wr_q.size(), 4);
    chk("run1_wr0", wr_q[0], {16'd2, 8'h00});
    chk("run1_wr1", wr_q[1], {16'd3, 8'h04});
    chk("run1_wr2", wr_q[2], {16'd4, 8'h00});
    chk("run1_wr3", wr_q[3], {16'd1, 8'h00});
    chk_bytes("run1", 4);
    for (int i = 1; i < 4; i++)
      chk("run1_spacing", acc_cyc[i] - acc_cyc[i-1], 3);
    chk("run1_ndone", done_cnt, 1);
    chk("run1_timeout", to_cnt, 0);
    chk("run1_idle", BUSY, 0);

    // same run with a slow consumer
    clr();
    rdy_mode = 1;
    start_run(16'd4, 1'b0);
    wait_done(300, "run2_done_seen");
    chk_bytes("run2", 4);
    chk("run2_ndone", done_cnt, 1);
    chk("run2_stable", stab_err, 0);
    chk("run2_no_rd_while_valid", rdv_err, 0);
    rdy_mode = 0;

    // COUNT=0, plus a START in the FIN cycle
    clr();
    step();
    START = 1'b1;
    COUNT = 16'd0;
    EXT_EN = 1'b0;
    @(negedge BUS_CLK);
    chk("cnt0_done_start_cyc", DONE, 0);
    step();
    COUNT = 16'd4;
    @(negedge BUS_CLK);
    chk("cnt0_done_pulse", DONE, 1);
    chk("cnt0_busy_fin", BUSY, 1);
    step();
    START = 1'b0;
    @(negedge BUS_CLK);
    chk("cnt0_done_low", DONE, 0);
    chk("cnt0_fin_start_ignored", BUSY, 0);
    repeat (3) step();
    chk("cnt0_nwr", wr_q.size(), 0);
    chk("cnt0_nrd", rd_cnt, 0);

    // COUNT above memory size is clamped
    clr();
    start_run(16'd9000, 1'b0);
    repeat (6) step();
    chk("clamp_nwr", wr_q.size(), 4);
    chk("clamp_lo", wr_q[1], {16'd3, 8'h00});
    chk("clamp_hi", wr_q[2], {16'd4, 8'h20});
    pulse_rst();

    // external trigger, with an ignored mid-run START
    clr();
    start_run(16'd2, 1'b1);
    repeat (30) step();
    chk("ext_busy", BUSY, 1);
    chk("ext_no_done", done_cnt, 0);
    chk("ext_nwr", wr_q.size(), 3);
    chk("ext_wr0", wr_q[0], {16'd2, 8'h01});
    chk("ext_wr1", wr_q[1], {16'd3, 8'h02});
    chk("ext_polling", rd_cnt > 5, 1);
    start_run(16'd1, 1'b0);
    step();
    ext_go = 1'b1;
    step();
    ext_go = 1'b0;
    wait_done(200, "ext_done_seen");
    chk("ext_nwr_after", wr_q.size(), 3);
    chk_bytes("ext", 2);

    // reset while a byte is being offered
    clr();
    rdy_mode = 2;
    start_run(16'd4, 1'b0);
    begin
      int n = 0;
      while (!DATA_VALID && n < 200) begin
        @(negedge BUS_CLK);
        n++;
      end
      chk("rstpush_reached", DATA_VALID, 1);
    end
    step();
    RST = 1'b1;
    @(posedge BUS_CLK);
    @(negedge BUS_CLK);
    chk("rstpush_busy", BUSY, 0);
    chk("rstpush_dv", DATA_VALID, 0);
    chk("rstpush_data", DATA, 0);
    chk("rstpush_add", REC_ADD, 0);
    chk("rstpush_dout", REC_DOUT, 0);
    chk("rstpush_strobes", {REC_WR, REC_RD, DONE, TIMEOUT}, 0);
    step();
    RST = 1'b0;
    chk("rstpush_no_srst", wr_q.size(), 4);
    clr();
    rdy_mode = 0;
    start_run(16'd2, 1'b0);
    wait_done(300, "rstpush_rerun_done");
    chk_bytes("rstpush_rerun", 2);

    // recorder never finishes
    clr();
    never_done = 1'b1;
    start_run(16'd4, 1'b0);
`ifdef SEQ_REC_CTRL_TIMEOUT_EN
    wait_done(300, "to_done_seen");
    chk("to_npolls", rd_cnt, 8);
    chk("to_nwr", wr_q.size(), 5);
    chk("to_srst", wr_q[4], {16'd0, 8'h00});
    chk("to_npulse", to_cnt, 1);
    chk("to_with_done", both_cnt, 1);
`else
    repeat (1000) step();
    chk("nto_busy", BUSY, 1);
    chk("nto_no_done", done_cnt, 0);
    chk("nto_no_timeout", to_cnt, 0);
    chk("nto_polling", rd_cnt >= 400, 1);
    pulse_rst();
`endif
    never_done = 1'b0;

    chk("never_rd_and_wr", rw_err, 0);
    chk("never_rd_while_valid", rdv_err, 0);
    chk("data_held_stable", stab_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
